mem_access: RTL and testbench

Memory stage of the in-order pipeline, directly downstream of `execute`. It consumes the registered instruction and ALU result (the effective address for loads/stores). It runs a request/grant/response handshake with data memory and returns write-back data with RV32I load sign/zero extension. Non-memory instructions pass through with one cycle of latency. While a memory access is outstanding, the stage stalls upstream and emits NOP bubbles downstream.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/mem_access_if.sv | 24 ++
 rtl/lsu_align.sv | 59 +++++
 rtl/mem_access.sv | 138 +++++++++++++
 tb/tb_mem_access.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and memory-stage types.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/grant/response bus.
interface mem_access_if;
  import riscv_pkg::*;

  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [BE_W-1:0] dmem_be_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store byte enables/replicated data and load extraction/extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            is_store,
  input  logic [XLEN-1:0] rs2,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata,
  input  logic [1:0]      ld_addr_lo,
  input  logic [2:0]      ld_funct3,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lanes; loads share the byte-enable rule but carry no data.
  always_comb begin
    be    = '0;
    wdata = '0;
    case (size)
      2'b00: begin
        be = BE_W'(4'b0001 << addr_lo);
        if (is_store) wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        be = addr_lo[1] ? 4'b1100 : 4'b0011;
        if (is_store) wdata = {2{rs2[15:0]}};
      end
      default: begin
        be = 4'b1111;
        if (is_store) wdata = rs2;
      end
    endcase
  end

  always_comb begin
    ld_byte   = '0;
    ld_half   = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (ld_addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    case (ld_funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {24'h0, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data = {16'h0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Pipeline memory stage: issues loads/stores over the dmem bus, stalls upstream
// while an access is outstanding, and passes other instructions through.
module mem_access
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic              stall_o,
  mem_access_if.master      dmem,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o
);

  mem_state_e      state_q, state_d;
  dmem_req_t       req_q, req_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic [XLEN-1:0] instr_o_d, wb_data_d;
  logic            misalign_d;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            is_load, is_store, misaligned;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c, load_data;

  assign opcode   = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign is_load  = (opcode == OP_LOAD) &&
                    (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  assign is_store = (opcode == OP_STORE) && (f3 == F3_B || f3 == F3_H || f3 == F3_W);
  // f3[1:0] is 01 for H/HU and 10 for W, for both loads and stores
  assign misaligned = ((f3[1:0] == 2'b01) && alu_result_i[0]) ||
                      ((f3[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));

  lsu_align u_align (
    .addr_lo    (alu_result_i[1:0]),
    .size       (f3[1:0]),
    .is_store   (is_store),
    .rs2        (rs2_i),
    .be         (be_c),
    .wdata      (wdata_c),
    .ld_addr_lo (lo_q),
    .ld_funct3  (f3_q),
    .rdata      (dmem.dmem_rdata_i),
    .load_data  (load_data)
  );

  // Bus outputs come only from state and latched request registers.
  assign stall_o           = (state_q != IDLE);
  assign dmem.dmem_req_o   = (state_q == REQ);
  assign dmem.dmem_we_o    = req_q.we;
  assign dmem.dmem_addr_o  = req_q.addr;
  assign dmem.dmem_be_o    = req_q.be;
  assign dmem.dmem_wdata_o = req_q.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    instr_d    = instr_q;
    f3_d       = f3_q;
    lo_d       = lo_q;
    instr_o_d  = NOP;
    wb_data_d  = '0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load || is_store) begin
          if (misaligned) begin
            instr_o_d  = instr_i;
            misalign_d = 1'b1;
          end else begin
            state_d     = REQ;
            req_d.we    = is_store;
            req_d.addr  = {alu_result_i[XLEN-1:2], 2'b00};
            req_d.be    = be_c;
            req_d.wdata = wdata_c;
            instr_d     = instr_i;
            f3_d        = f3;
            lo_d        = alu_result_i[1:0];
          end
        end else begin
          instr_o_d = instr_i;
          wb_data_d = alu_result_i;
        end
      end
      REQ: begin
        if (dmem.dmem_gnt_i) begin
          if (req_q.we) begin
            state_d   = IDLE;
            instr_o_d = instr_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid_i) begin
          state_d   = IDLE;
          instr_o_d = instr_q;
          wb_data_d = load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      instr_q    <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      instr_o    <= '0;
      wb_data_o  <= '0;
      misalign_o <= 1'b0;
    end else begin
      req_q      <= req_d;
      instr_q    <= instr_d;
      f3_q       <= f3_d;
      lo_q       <= lo_d;
      instr_o    <= instr_o_d;
      wb_data_o  <= wb_data_d;
      misalign_o <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed loads/stores/pass-through with a retire monitor.
module tb_mem_access;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i, alu_result_i, rs2_i;
  logic        stall_o;
  logic [31:0] instr_o, wb_data_o;
  logic        misalign_o;

  mem_access_if dmem();

  mem_access dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_i      (instr_i),
    .alu_result_i (alu_result_i),
    .rs2_i        (rs2_i),
    .stall_o      (stall_o),
    .dmem         (dmem),
    .instr_o      (instr_o),
    .wb_data_o    (wb_data_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD = {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] I_LB  = {12'h0, 5'd1, 3'b000, 5'd5, 7'b0000011};
  localparam logic [31:0] I_LH  = {12'h0, 5'd1, 3'b001, 5'd5, 7'b0000011};
  localparam logic [31:0] I_LW  = {12'h0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] I_LBU = {12'h0, 5'd1, 3'b100, 5'd5, 7'b0000011};
  localparam logic [31:0] I_LHU = {12'h0, 5'd1, 3'b101, 5'd5, 7'b0000011};
  localparam logic [31:0] I_SB  = {7'b0, 5'd2, 5'd1, 3'b000, 5'b0, 7'b0100011};
  localparam logic [31:0] I_SH  = {7'b0, 5'd2, 5'd1, 3'b001, 5'b0, 7'b0100011};
  localparam logic [31:0] I_SW  = {7'b0, 5'd2, 5'd1, 3'b010, 5'b0, 7'b0100011};

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] wb;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Retire monitor: every non-bubble instruction on instr_o must match the next expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (instr_o != NOP && instr_o != 32'h0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected retire: got %h expected none", instr_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("retire instr", instr_o, e.instr);
          check("retire wb_data", wb_data_o, e.wb);
          check("retire misalign", 32'(misalign_o), 32'(e.mis));
        end
      end else begin
        check("bubble wb_data", wb_data_o, 32'h0);
        check("bubble misalign", 32'(misalign_o), 32'h0);
      end
    end
  end

  task automatic pass_op(input logic [31:0] ins, input logic [31:0] alu);
    exp_q.push_back('{instr: ins, wb: alu, mis: 1'b0});
    instr_i = ins; alu_result_i = alu; rs2_i = 32'h0;
    @(negedge clk);
    check("pass stall", 32'(stall_o), 32'h0);
    check("pass req", 32'(dmem.dmem_req_o), 32'h0);
    @(posedge clk); #1;
    check("pass latency", instr_o, ins);
    instr_i = NOP; alu_result_i = 32'h0;
  endtask

  task automatic mis_op(input logic [31:0] ins, input logic [31:0] alu);
    exp_q.push_back('{instr: ins, wb: 32'h0, mis: 1'b1});
    instr_i = ins; alu_result_i = alu; rs2_i = 32'h5555_AAAA;
    @(negedge clk);
    check("misalign stall", 32'(stall_o), 32'h0);
    check("misalign req", 32'(dmem.dmem_req_o), 32'h0);
    @(posedge clk); #1;
    check("misalign pulse", 32'(misalign_o), 32'h1);
    instr_i = NOP; alu_result_i = 32'h0; rs2_i = 32'h0;
  endtask

  task automatic mem_op(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                        input bit ld, input int gw, input int rw, input logic [31:0] rdata,
                        input logic [31:0] exp_wb, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    exp_q.push_back('{instr: ins, wb: exp_wb, mis: 1'b0});
    instr_i = ins; alu_result_i = alu; rs2_i = rs2;
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0;
    @(negedge clk);
    check("issue stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;
    check("issue bubble", instr_o, NOP);
    for (int k = 0; k <= gw; k++) begin
      dmem.dmem_gnt_i    = (k == gw);
      dmem.dmem_rvalid_i = (k != gw);
      dmem.dmem_rdata_i  = 32'hBAD0_BAD0;
      @(negedge clk);
      check("req held", 32'(dmem.dmem_req_o), 32'h1);
      check("req stall", 32'(stall_o), 32'h1);
      if (k == 0) begin
        check("dmem_addr", dmem.dmem_addr_o, exp_addr);
        check("dmem_be", 32'(dmem.dmem_be_o), 32'(exp_be));
        check("dmem_wdata", dmem.dmem_wdata_o, exp_wdata);
        check("dmem_we", 32'(dmem.dmem_we_o), ld ? 32'h0 : 32'h1);
      end
      @(posedge clk); #1;
    end
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0;
    if (ld) begin
      for (int j = 0; j <= rw; j++) begin
        dmem.dmem_rvalid_i = (j == rw);
        dmem.dmem_gnt_i    = (j != rw);
        dmem.dmem_rdata_i  = (j == rw) ? rdata : 32'hBAD0_BAD0;
        @(negedge clk);
        check("wait req low", 32'(dmem.dmem_req_o), 32'h0);
        check("wait stall", 32'(stall_o), 32'h1);
        @(posedge clk); #1;
      end
    end
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = 32'h0;
    check("retire latency", instr_o, ins);
    check("retire value", wb_data_o, exp_wb);
    instr_i = NOP; alu_result_i = 32'h0; rs2_i = 32'h0;
  endtask

  initial begin
    instr_i = NOP; alu_result_i = 32'h0; rs2_i = 32'h0;
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = 32'h0;
    rst_n = 1'b0;
    #2;
    check("reset instr_o", instr_o, 32'h0);
    check("reset wb_data", wb_data_o, 32'h0);
    check("reset misalign", 32'(misalign_o), 32'h0);
    check("reset stall", 32'(stall_o), 32'h0);
    check("reset req", 32'(dmem.dmem_req_o), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    pass_op(I_ADD, 32'h0000_1234);
    mem_op(I_LB,  32'h0000_100A, 32'h0, 1'b1, 0, 0, 32'h0080_0000, 32'hFFFF_FF80, 32'h1008, 4'b0100, 32'h0);
    mem_op(I_LBU, 32'h0000_100A, 32'h0, 1'b1, 0, 0, 32'h0080_0000, 32'h0000_0080, 32'h1008, 4'b0100, 32'h0);
    mem_op(I_SH,  32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 3, 0, 32'h0, 32'h0, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
    mis_op(I_LW, 32'h0000_3001);
    mis_op(I_SH, 32'h0000_2001);
    mem_op(I_LH,  32'h0000_2006, 32'h0, 1'b1, 0, 1, 32'h8001_0000, 32'hFFFF_8001, 32'h2004, 4'b1100, 32'h0);
    mem_op(I_LHU, 32'h0000_2004, 32'h0, 1'b1, 0, 0, 32'h1234_F00D, 32'h0000_F00D, 32'h2004, 4'b0011, 32'h0);
    mem_op(I_SB,  32'h0000_3003, 32'h1234_5678, 1'b0, 0, 0, 32'h0, 32'h0, 32'h3000, 4'b1000, 32'h7878_7878);
    mem_op(I_SW,  32'h0000_3004, 32'hCAFE_F00D, 1'b0, 1, 0, 32'h0, 32'h0, 32'h3004, 4'b1111, 32'hCAFE_F00D);
    mem_op(I_LW,  32'h0000_3008, 32'h0, 1'b1, 1, 2, 32'h1357_9BDF, 32'h1357_9BDF, 32'h3008, 4'b1111, 32'h0);
    // back-to-back load then pass-through with no dead cycle
    mem_op(I_LW,  32'h0000_4000, 32'h0, 1'b1, 0, 0, 32'hA5A5_0001, 32'hA5A5_0001, 32'h4000, 4'b1111, 32'h0);
    pass_op(I_ADD, 32'h0000_0055);

    // Reset while a load waits for its response
    instr_i = I_LW; alu_result_i = 32'h0000_5000;
    @(posedge clk); #1;
    dmem.dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem.dmem_gnt_i = 1'b0;
    check("pre-reset stall", 32'(stall_o), 32'h1);
    #2; rst_n = 1'b0; #1;
    check("async reset req", 32'(dmem.dmem_req_o), 32'h0);
    check("async reset stall", 32'(stall_o), 32'h0);
    check("async reset instr_o", instr_o, 32'h0);
    check("async reset addr", dmem.dmem_addr_o, 32'h0);
    check("async reset be", 32'(dmem.dmem_be_o), 32'h0);
    instr_i = NOP; alu_result_i = 32'h0;
    @(negedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'hDEAD_DEAD;
    @(negedge clk);
    check("late rvalid stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1;
    dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = 32'h0;
    check("late rvalid instr", instr_o, NOP);
    check("late rvalid wb", wb_data_o, 32'h0);

    pass_op(I_ADD, 32'h0000_0099);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
